pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the PC and the data path.
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning the text-segment base and the PC reset value.
REQ-003 SHALL have parameter MEMORY_DEPTH, default 32, meaning the number of program-memory words; the legal PC range is [RESET_PC, RESET_PC+4*MEMORY_DEPTH).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable_i, input, 1 bit: 1 = advance the PC this cycle, 0 = stall.
REQ-007 SHALL have port branch_taken_i, input, 1 bit: a conditional branch resolved as taken.
REQ-008 SHALL have port branch_offset_i, input, 16 bits: the branch immediate, a signed word offset.
REQ-009 SHALL have port jump_i, input, 1 bit: J/JAL.
REQ-010 SHALL have port jump_index_i, input, 26 bits: the J-type target index.
REQ-011 SHALL have port jump_reg_i, input, 1 bit: JR.
REQ-012 SHALL have port jump_reg_addr_i, input, DATA_WIDTH: the JR target register value.
REQ-013 SHALL have port restart_i, input, 1 bit: synchronous return to RESET_PC that clears a fault.
REQ-014 SHALL have port pc_o, output, DATA_WIDTH: the current PC, which drives the program-memory address.
REQ-015 SHALL have port pc_plus4_o, output, DATA_WIDTH: pc_o+4, the JAL link value.
REQ-016 SHALL have port fault_o, output, 1 bit: sticky fetch fault.
REQ-017 SHALL have port fault_code_o, output, 2 bits: 00 none, 01 misaligned, 10 out of range.
REQ-018 SHALL have port retired_count_o, output, 32 bits: the count of PC updates.

Function
REQ-019 SHALL implement a two-state FSM, RUN and FAULT.
REQ-020 SHALL compute next-PC with priority jump_reg_i > jump_i > branch_taken_i > sequential.
- JR: jump_reg_addr_i
- J: {pc_plus4[31:28], jump_index_i, 2'b00}
- branch: pc_plus4 + (sign-extended branch_offset_i << 2), modulo 2^32
- sequential: pc_plus4
REQ-021 SHALL drive pc_plus4_o combinationally as pc_o+4, wrapping modulo 2^32.
REQ-022 In RUN with enable_i=1 and a legal candidate, SHALL load the candidate into the PC on the next edge (one-cycle latency) and increment retired_count_o.
REQ-023 SHALL treat a candidate with bits [1:0] != 00 as misaligned.
- Takes precedence over out-of-range when both apply.
- PC SHALL hold; FSM SHALL enter FAULT; fault_code_o=01.
REQ-024 SHALL treat an aligned candidate outside the legal range as out of range.
- PC SHALL hold; FSM SHALL enter FAULT; fault_code_o=10.
REQ-025 With enable_i=0, SHALL hold the PC, counter and state; branch/jump inputs are ignored.
REQ-026 In FAULT, SHALL hold the PC, counter and fault_code_o regardless of enable_i or control inputs.
REQ-027 restart_i=1 SHALL, on the next edge in any state and irrespective of enable_i:
- set PC to RESET_PC;
- clear fault_o and fault_code_o to 00;
- enter RUN;
- leave retired_count_o unchanged.
REQ-028 restart_i SHALL take priority over every other control input in the same cycle.
REQ-029 retired_count_o SHALL wrap from 32'hFFFF_FFFF to 0 without affecting state.
REQ-030 fault_o SHALL be 1 exactly when the FSM is in FAULT.

Reset
REQ-031 reset=0 SHALL immediately, without waiting for a clock edge, set:
- pc_o = RESET_PC;
- state = RUN;
- fault_o = 0;
- fault_code_o = 00;
- retired_count_o = 0.
REQ-032 Reset asserted mid-operation, including in FAULT, SHALL override all inputs; the first update after deassertion SHALL occur on the first rising edge with reset=1.

Verification
REQ-033 Reset release, then enable_i=1 for 3 cycles -> pc_o 0x00400000, 0x00400004, 0x00400008, 0x0040000C; retired_count_o=3.
REQ-034 pc_o=0x00400010, branch_taken_i=1, offset 16'hFFFC -> pc_o=0x00400004; same cycle with jump_i=1 and index 26'h0100003 -> pc_o=0x0040000C (jump wins).
REQ-035 jump_reg_i=1, addr 0x00400006 -> fault_o=1, fault_code_o=01, pc_o unchanged; addr 0x00400080 -> fault_code_o=10.
REQ-036 In FAULT, pulse restart_i -> pc_o=0x00400000, fault_o=0, retired_count_o unchanged; enable_i=0 for 5 cycles -> pc_o and counter frozen.
REQ-037 Assert reset asynchronously between edges while pc_o=0x00400014 -> pc_o=0x00400000 immediately; preload counter 0xFFFFFFFF, step once -> 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter fetch stage. It holds the current PC and picks the next PC
// from jump-register, jump, taken-branch or sequential flow, in that order of
// priority. A candidate PC that is misaligned, or that lies outside the program
// memory window [RESET_PC, RESET_PC + 4*MEMORY_DEPTH), is refused. The PC then
// holds and the unit parks in FAULT until restart_i or reset. Each accepted PC
// update increments a free-running retired counter.
//
// Ports
//   clk              : clock; all state updates on the rising edge
//   reset            : asynchronous, active-low reset
//   enable_i         : 1 = advance the PC this cycle, 0 = stall
//   branch_taken_i   : conditional branch resolved as taken
//   branch_offset_i  : signed 16-bit word offset of the branch
//   jump_i           : J/JAL
//   jump_index_i     : 26-bit J-type target index
//   jump_reg_i       : JR
//   jump_reg_addr_i  : JR target register value
//   restart_i        : synchronous return to RESET_PC; clears a fault
//   pc_o             : current PC (program-memory address)
//   pc_plus4_o       : pc_o + 4 (JAL link value)
//   fault_o          : high while parked in FAULT
//   fault_code_o     : 00 none, 01 misaligned, 10 out of range
//   retired_count_o  : number of accepted PC updates (wraps)
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = 32'h0040_0000,
  parameter int                    MEMORY_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  branch_taken_i,
  input  logic [15:0]           branch_offset_i,
  input  logic                  jump_i,
  input  logic [25:0]           jump_index_i,
  input  logic                  jump_reg_i,
  input  logic [DATA_WIDTH-1:0] jump_reg_addr_i,
  input  logic                  restart_i,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  fault_o,
  output logic [1:0]            fault_code_o,
  output logic [31:0]           retired_count_o
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_MISALIGNED = 2'b01,
    FC_RANGE      = 2'b10
  } fault_code_e;

  // Window bounds carry one extra bit so RESET_PC + 4*MEMORY_DEPTH cannot wrap.
  localparam logic [DATA_WIDTH:0] PC_LO = {1'b0, RESET_PC};
  localparam logic [DATA_WIDTH:0] PC_HI = PC_LO + (DATA_WIDTH+1)'(4 * MEMORY_DEPTH);

  state_e                state_q, state_d;
  fault_code_e           fault_code_q, fault_code_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]           retired_q, retired_d;

  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] branch_offset_ext;
  logic [DATA_WIDTH-1:0] branch_target;
  logic [DATA_WIDTH-1:0] jump_target;
  logic [DATA_WIDTH-1:0] candidate;
  logic                  cand_misaligned;
  logic                  cand_in_range;

  // Target arithmetic wraps modulo 2^DATA_WIDTH by truncation.
  assign pc_plus4          = pc_q + DATA_WIDTH'(4);
  assign branch_offset_ext = {{(DATA_WIDTH-16){branch_offset_i[15]}}, branch_offset_i};
  assign branch_target     = pc_plus4 + (branch_offset_ext << 2);
  assign jump_target       = {pc_plus4[DATA_WIDTH-1:28], jump_index_i, 2'b00};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    candidate = pc_plus4;
    if (jump_reg_i) begin
      candidate = jump_reg_addr_i;
    end else if (jump_i) begin
      candidate = jump_target;
    end else if (branch_taken_i) begin
      candidate = branch_target;
    end
  end

  assign cand_misaligned = (candidate[1:0] != 2'b00);
  assign cand_in_range   = ({1'b0, candidate} >= PC_LO) && ({1'b0, candidate} < PC_HI);

  // Next-state logic. restart_i outranks everything; in RUN a stall holds the
  // state, and a refused candidate parks the unit in FAULT with the PC held.
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    pc_d         = pc_q;
    retired_d    = retired_q;

    if (restart_i) begin
      state_d      = ST_RUN;
      fault_code_d = FC_NONE;
      pc_d         = RESET_PC;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (enable_i) begin
            // Misalignment is reported in preference to out-of-range.
            if (cand_misaligned) begin
              state_d      = ST_FAULT;
              fault_code_d = FC_MISALIGNED;
            end else if (!cand_in_range) begin
              state_d      = ST_FAULT;
              fault_code_d = FC_RANGE;
            end else begin
              pc_d      = candidate;
              retired_d = retired_q + 32'd1;
            end
          end
        end
        ST_FAULT: begin
          // Hold everything until restart_i or reset.
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      fault_code_q <= FC_NONE;
      pc_q         <= RESET_PC;
      retired_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      fault_code_q <= fault_code_d;
      pc_q         <= pc_d;
      retired_q    <= retired_d;
    end
  end

  assign pc_o            = pc_q;
  assign pc_plus4_o      = pc_plus4;
  assign fault_o         = (state_q == ST_FAULT);
  assign fault_code_o    = fault_code_q;
  assign retired_count_o = retired_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Directed bench for pc_fetch_unit. The stimulus process drives inputs on the
// falling edge and, after each rising edge, pushes the hand-computed expected
// state into a queue. A separate monitor pops one entry per falling edge and
// compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam int          DW       = 32;
  localparam logic [31:0] BASE     = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        branch_taken_i;
  logic [15:0] branch_offset_i;
  logic        jump_i;
  logic [25:0] jump_index_i;
  logic        jump_reg_i;
  logic [31:0] jump_reg_addr_i;
  logic        restart_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        fault_o;
  logic [1:0]  fault_code_o;
  logic [31:0] retired_count_o;

  pc_fetch_unit #(
    .DATA_WIDTH  (DW),
    .RESET_PC    (BASE),
    .MEMORY_DEPTH(32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable_i),
    .branch_taken_i (branch_taken_i),
    .branch_offset_i(branch_offset_i),
    .jump_i         (jump_i),
    .jump_index_i   (jump_index_i),
    .jump_reg_i     (jump_reg_i),
    .jump_reg_addr_i(jump_reg_addr_i),
    .restart_i      (restart_i),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .fault_o        (fault_o),
    .fault_code_o   (fault_code_o),
    .retired_count_o(retired_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] pc, input logic [31:0] cnt,
                      input logic f, input logic [1:0] code);
    exp_t e;
    e.pc    = pc;
    e.cnt   = cnt;
    e.fault = f;
    e.code  = code;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Drive one cycle's inputs on the falling edge.
  task automatic drive(input logic en, input logic br, input logic [15:0] off,
                       input logic j, input logic [25:0] idx,
                       input logic jr, input logic [31:0] jra, input logic rs);
    @(negedge clk);
    enable_i        = en;
    branch_taken_i  = br;
    branch_offset_i = off;
    jump_i          = j;
    jump_index_i    = idx;
    jump_reg_i      = jr;
    jump_reg_addr_i = jra;
    restart_i       = rs;
  endtask

  // Expected state after the coming rising edge.
  task automatic expect_next(input string nm, input logic [31:0] pc, input logic [31:0] cnt,
                             input logic f, input logic [1:0] code);
    @(posedge clk);
    push(nm, pc, cnt, f, code);
  endtask

  // Monitor: one scoreboard entry per falling edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check({nm, ".pc"},       pc_o,                    e.pc);
        check({nm, ".pc_plus4"}, pc_plus4_o,              e.pc + 32'd4);
        check({nm, ".fault"},    {31'd0, fault_o},        {31'd0, e.fault});
        check({nm, ".code"},     {30'd0, fault_code_o},   {30'd0, e.code});
        check({nm, ".count"},    retired_count_o,         e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b0;
    enable_i        = 1'b0;
    branch_taken_i  = 1'b0;
    branch_offset_i = 16'h0;
    jump_i          = 1'b0;
    jump_index_i    = 26'h0;
    jump_reg_i      = 1'b0;
    jump_reg_addr_i = 32'h0;
    restart_i       = 1'b0;

    #2;
    push("reset", BASE, 32'd0, 1'b0, 2'b00);
    @(negedge clk);
    reset = 1'b1;

    // Sequential fetch.
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("seq1", 32'h0040_0004, 1, 0, 2'b00);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("seq2", 32'h0040_0008, 2, 0, 2'b00);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("seq3", 32'h0040_000C, 3, 0, 2'b00);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("seq4", 32'h0040_0010, 4, 0, 2'b00);

    // Backward branch: 0x400014 + (-4 << 2) = 0x400004.
    drive(1, 1, 16'hFFFC, 0, 26'h0, 0, 32'h0, 0); expect_next("br_back", 32'h0040_0004, 5, 0, 2'b00);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("seq5", 32'h0040_0008, 6, 0, 2'b00);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("seq6", 32'h0040_000C, 7, 0, 2'b00);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("seq7", 32'h0040_0010, 8, 0, 2'b00);

    // Jump beats branch in the same cycle.
    drive(1, 1, 16'hFFFC, 1, 26'h0100003, 0, 32'h0, 0); expect_next("jump_wins", 32'h0040_000C, 9, 0, 2'b00);
    // Forward branch: 0x400010 + (3 << 2) = 0x40001C.
    drive(1, 1, 16'h0003, 0, 26'h0, 0, 32'h0, 0); expect_next("br_fwd", 32'h0040_001C, 10, 0, 2'b00);
    // JR beats jump and branch (jump index 0 would be out of range).
    drive(1, 1, 16'h0001, 1, 26'h0, 1, 32'h0040_0020, 0); expect_next("jr_wins", 32'h0040_0020, 11, 0, 2'b00);
    // Stall ignores the branch.
    drive(0, 1, 16'h0001, 0, 26'h0, 0, 32'h0, 0); expect_next("stall", 32'h0040_0020, 11, 0, 2'b00);

    // Misaligned JR.
    drive(1, 0, 16'h0, 0, 26'h0, 1, 32'h0040_0006, 0); expect_next("misalign", 32'h0040_0020, 11, 1, 2'b01);
    // FAULT holds even with a legal request.
    drive(1, 0, 16'h0, 0, 26'h0, 1, 32'h0040_0000, 0); expect_next("fault_hold", 32'h0040_0020, 11, 1, 2'b01);
    // Restart outranks enable and jump.
    drive(1, 0, 16'h0, 1, 26'h0100003, 0, 32'h0, 1); expect_next("restart1", BASE, 11, 0, 2'b00);
    // Out of range just past the top.
    drive(1, 0, 16'h0, 0, 26'h0, 1, 32'h0040_0080, 0); expect_next("range_top", BASE, 11, 1, 2'b10);
    drive(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1); expect_next("restart2", BASE, 11, 0, 2'b00);
    // Misaligned and out of range: misaligned reported.
    drive(1, 0, 16'h0, 0, 26'h0, 1, 32'h0050_0002, 0); expect_next("mis_over_rng", BASE, 11, 1, 2'b01);
    drive(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1); expect_next("restart3", BASE, 11, 0, 2'b00);

    // Five stall cycles.
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 16'h0004, 1, 26'h0100003, 1, 32'h0040_0040, 0);
      expect_next("freeze", BASE, 11, 0, 2'b00);
    end

    // Last legal word, then sequential fetch off the end.
    drive(1, 0, 16'h0, 0, 26'h0, 1, 32'h0040_007C, 0); expect_next("last_word", 32'h0040_007C, 12, 0, 2'b00);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("seq_off_end", 32'h0040_007C, 12, 1, 2'b10);
    drive(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1); expect_next("restart4", BASE, 12, 0, 2'b00);
    // Just below the base.
    drive(1, 0, 16'h0, 0, 26'h0, 1, 32'h003F_FFFC, 0); expect_next("range_low", BASE, 12, 1, 2'b10);
    drive(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1); expect_next("restart5", BASE, 12, 0, 2'b00);

    // Walk up to 0x400014.
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
      expect_next("walk", BASE + 32'(4 * i), 32'(12 + i), 0, 2'b00);
    end

    // Asynchronous reset between edges; released before the next rising edge.
    drive(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    push("async_reset", BASE, 32'd0, 0, 2'b00);
    @(negedge clk);
    #2;
    reset = 1'b1;

    // Counter wrap from all-ones.
    @(posedge clk);
    #1;
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    push("preload", BASE, 32'hFFFF_FFFF, 0, 2'b00);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("wrap", 32'h0040_0004, 32'd0, 0, 2'b00);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0); expect_next("after_wrap", 32'h0040_0008, 32'd1, 0, 2'b00);
    drive(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
